// File: rtl/dpram_fifo_pkg.sv
// Shared pointer helpers for the dual-port RAM FIFO controller.
// Pointers carry one extra wrap bit above the RAM address.
package dpram_fifo_pkg;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic logic ptr_full(
    input logic [31:0] wr,
    input logic [31:0] rd,
    input int          aw
  );
    logic [31:0] lo;
    lo = (32'd1 << aw) - 32'd1;
    return (wr[aw] != rd[aw]) &&
           ((wr & lo) == (rd & lo));
  endfunction

  function automatic logic [31:0] ptr_count(
    input logic [31:0] wr,
    input logic [31:0] rd,
    input int          aw
  );
    logic [31:0] m;
    m = (32'd1 << (aw + 1)) - 32'd1;
    return (wr - rd) & m;
  endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_ptr.sv
// Wrapping pointer with an extra wrap bit; one per FIFO side.
// Rolls over naturally so the wrap bit toggles every DEPTH steps.
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM (A write, B read).
// Holds only pointers, flags and the one-cycle read-valid pipeline.
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int AF_THRESH  = DEPTH - 16,
  localparam int ADDR_W    = addr_w(DEPTH),
  localparam int PW        = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [PW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_wr_en,
  output logic [ADDR_W-1:0]     ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_W-1:0]     ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_acc;
  logic          pop_acc;

  fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop_acc),
    .ptr   (rd_ptr)
  );

  assign empty = (wr_ptr == rd_ptr);
  assign full  = ptr_full(32'(wr_ptr),
                          32'(rd_ptr), ADDR_W);
  assign count = PW'(ptr_count(32'(wr_ptr),
                               32'(rd_ptr), ADDR_W));
  assign almost_full =
    (32'(count) >= 32'(AF_THRESH));

  // A push while full is refused even alongside a pop.
  assign push_acc = push & ~full;
  assign pop_acc  = pop & ~empty;

  assign ram_wr_en   = push_acc;
  assign ram_wr_addr = wr_ptr[ADDR_W-1:0];
  assign ram_wr_data = push_data;
  assign ram_rd_en   = pop_acc;
  assign ram_rd_addr = rd_ptr[ADDR_W-1:0];

  // RAM output register already holds data; no local copy.
  assign pop_data = ram_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= pop_acc;
      overflow  <= push & full;
      underflow <= pop & empty;
    end
  end

endmodule
